// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_operand_stage
//  Purpose  : Pipeline register between decode / register-file read and the
//             combinational ALU. Resolves EX/MEM and MEM/WB operand
//             forwarding at capture time, selects immediate vs. rs2 for
//             operand2, and holds one instruction under a valid/ready
//             handshake with flush support.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             in_valid / in_ready   - upstream handshake
//             in_*                  - decoded instruction payload
//             flush                 - drop held instruction, block capture
//             fwd_exmem_*, fwd_memwb_* - forwarding sources
//             out_valid / out_ready - downstream handshake
//             operand1, operand2, ALUControl, funct3, funct7,
//             store_data, rd, reg_write - registered ALU-side payload
//  Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_alu_src,
    input  logic [2:0]            in_ALUControl,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,

    input  logic                  flush,

    input  logic                  fwd_exmem_we,
    input  logic [REG_ADDR_W-1:0] fwd_exmem_rd,
    input  logic [XLEN-1:0]       fwd_exmem_data,
    input  logic                  fwd_memwb_we,
    input  logic [REG_ADDR_W-1:0] fwd_memwb_rd,
    input  logic [XLEN-1:0]       fwd_memwb_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       operand1,
    output logic [XLEN-1:0]       operand2,
    output logic [2:0]            ALUControl,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [XLEN-1:0]       store_data,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  reg_write
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  out_valid_q,  out_valid_d;
    logic [XLEN-1:0]       operand1_q,   operand1_d;
    logic [XLEN-1:0]       operand2_q,   operand2_d;
    logic [2:0]            alu_ctrl_q,   alu_ctrl_d;
    logic [2:0]            funct3_q,     funct3_d;
    logic [6:0]            funct7_q,     funct7_d;
    logic [XLEN-1:0]       store_data_q, store_data_d;
    logic [REG_ADDR_W-1:0] rd_q,         rd_d;
    logic                  reg_write_q,  reg_write_d;

    logic                  w_capture;
    logic                  w_drain;
    logic [XLEN-1:0]       w_rs1_fwd;
    logic [XLEN-1:0]       w_rs2_fwd;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // A stalled stage still accepts when downstream is consuming this
    // cycle, so back-to-back transfers incur no bubble.
    assign in_ready  = !flush && (!out_valid_q || out_ready);
    assign w_capture = in_valid && in_ready;
    assign w_drain   = out_valid_q && out_ready && !w_capture;

    // ------------------------------------------------------------------
    // Forwarding: EX/MEM is the younger result and wins over MEM/WB.
    // x0 is hardwired zero and must never pick up a forwarded value.
    // ------------------------------------------------------------------
    always_comb begin
        w_rs1_fwd = in_rs1_data;
        if (in_rs1_addr != '0) begin
            if (fwd_exmem_we && (fwd_exmem_rd == in_rs1_addr)) begin
                w_rs1_fwd = fwd_exmem_data;
            end else if (fwd_memwb_we && (fwd_memwb_rd == in_rs1_addr)) begin
                w_rs1_fwd = fwd_memwb_data;
            end
        end
    end

    always_comb begin
        w_rs2_fwd = in_rs2_data;
        if (in_rs2_addr != '0) begin
            if (fwd_exmem_we && (fwd_exmem_rd == in_rs2_addr)) begin
                w_rs2_fwd = fwd_exmem_data;
            end else if (fwd_memwb_we && (fwd_memwb_rd == in_rs2_addr)) begin
                w_rs2_fwd = fwd_memwb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state. Flush dominates; capture gates off when flushing via
    // in_ready. Drain and flush leave the payload untouched except for
    // reg_write so a dead instruction can never commit.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d  = out_valid_q;
        operand1_d   = operand1_q;
        operand2_d   = operand2_q;
        alu_ctrl_d   = alu_ctrl_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;

        if (flush) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
        end else if (w_capture) begin
            out_valid_d  = 1'b1;
            operand1_d   = w_rs1_fwd;
            operand2_d   = in_alu_src ? in_imm : w_rs2_fwd;
            alu_ctrl_d   = in_ALUControl;
            funct3_d     = in_funct3;
            funct7_d     = in_funct7;
            store_data_d = w_rs2_fwd;
            rd_d         = in_rd;
            reg_write_d  = in_reg_write;
        end else if (w_drain) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            operand1_q   <= '0;
            operand2_q   <= '0;
            alu_ctrl_q   <= '0;
            funct3_q     <= '0;
            funct7_q     <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            operand1_q   <= operand1_d;
            operand2_q   <= operand2_d;
            alu_ctrl_q   <= alu_ctrl_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = out_valid_q;
    assign operand1   = operand1_q;
    assign operand2   = operand2_q;
    assign ALUControl = alu_ctrl_q;
    assign funct3     = funct3_q;
    assign funct7     = funct7_q;
    assign store_data = store_data_q;
    assign rd         = rd_q;
    assign reg_write  = reg_write_q && out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_operand_stage
//  Purpose  : Self-checking bench for ex_operand_stage. Expected payloads
//             are queued when an instruction is driven and compared when it
//             appears on the registered outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [XLEN-1:0]       in_imm;
    logic                  in_alu_src;
    logic [2:0]            in_ALUControl;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_write;
    logic                  flush;
    logic                  fwd_exmem_we;
    logic [REG_ADDR_W-1:0] fwd_exmem_rd;
    logic [XLEN-1:0]       fwd_exmem_data;
    logic                  fwd_memwb_we;
    logic [REG_ADDR_W-1:0] fwd_memwb_rd;
    logic [XLEN-1:0]       fwd_memwb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       operand1;
    logic [XLEN-1:0]       operand2;
    logic [2:0]            ALUControl;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;

    ex_operand_stage #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs2_addr    (in_rs2_addr),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_alu_src     (in_alu_src),
        .in_ALUControl  (in_ALUControl),
        .in_funct3      (in_funct3),
        .in_funct7      (in_funct7),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .flush          (flush),
        .fwd_exmem_we   (fwd_exmem_we),
        .fwd_exmem_rd   (fwd_exmem_rd),
        .fwd_exmem_data (fwd_exmem_data),
        .fwd_memwb_we   (fwd_memwb_we),
        .fwd_memwb_rd   (fwd_memwb_rd),
        .fwd_memwb_data (fwd_memwb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .operand1       (operand1),
        .operand2       (operand2),
        .ALUControl     (ALUControl),
        .funct3         (funct3),
        .funct7         (funct7),
        .store_data     (store_data),
        .rd             (rd),
        .reg_write      (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [2:0]  aluc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t zero_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every registered output against an expected record.
    task automatic check_out(input string tag, input exp_t e, input logic valid);
        check({tag, ".out_valid"},  32'(out_valid),  32'(valid));
        check({tag, ".operand1"},   operand1,        e.op1);
        check({tag, ".operand2"},   operand2,        e.op2);
        check({tag, ".store_data"}, store_data,      e.sd);
        check({tag, ".ALUControl"}, 32'(ALUControl), 32'(e.aluc));
        check({tag, ".funct3"},     32'(funct3),     32'(e.f3));
        check({tag, ".funct7"},     32'(funct7),     32'(e.f7));
        check({tag, ".rd"},         32'(rd),         32'(e.rd));
        check({tag, ".reg_write"},  32'(reg_write),  32'(e.rw & valid));
    endtask

    // Queue the expected result of the instruction currently being driven;
    // pass-through fields come from the bench's own stimulus.
    task automatic push_exp(input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] sd);
        exp_t e;
        e.op1  = op1;
        e.op2  = op2;
        e.sd   = sd;
        e.aluc = in_ALUControl;
        e.f3   = in_funct3;
        e.f7   = in_funct7;
        e.rd   = in_rd;
        e.rw   = in_reg_write;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Clock one edge and compare the output against the oldest queued entry.
    task automatic tick_pop(input string tag);
        tick();
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            cur = q.pop_front();
            check_out(tag, cur, 1'b1);
        end
    endtask

    task automatic set_instr(input logic [4:0] rs1a, input logic [4:0] rs2a,
                             input logic [31:0] rs1d, input logic [31:0] rs2d,
                             input logic [31:0] imm, input logic alu_src,
                             input logic [2:0] aluc, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rdv,
                             input logic rw);
        in_valid      = 1'b1;
        in_rs1_addr   = rs1a;
        in_rs2_addr   = rs2a;
        in_rs1_data   = rs1d;
        in_rs2_data   = rs2d;
        in_imm        = imm;
        in_alu_src    = alu_src;
        in_ALUControl = aluc;
        in_funct3     = f3;
        in_funct7     = f7;
        in_rd         = rdv;
        in_reg_write  = rw;
    endtask

    task automatic set_fwd(input logic ewe, input logic [4:0] erd, input logic [31:0] ed,
                           input logic mwe, input logic [4:0] mrd, input logic [31:0] md);
        fwd_exmem_we   = ewe;
        fwd_exmem_rd   = erd;
        fwd_exmem_data = ed;
        fwd_memwb_we   = mwe;
        fwd_memwb_rd   = mrd;
        fwd_memwb_data = md;
    endtask

    initial begin
        zero_e = '{op1: 32'h0, op2: 32'h0, sd: 32'h0, aluc: 3'h0, f3: 3'h0,
                   f7: 7'h0, rd: 5'h0, rw: 1'b0};
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'h0, 3'h0, 7'h0, 5'h0, 1'b0);
        in_valid  = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset: everything zero even with a valid request pending.
        in_valid = 1'b1;
        tick();
        tick();
        check_out("reset", zero_e, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // Basic issue, no forwarding.
        set_instr(5'd1, 5'd2, 32'h5, 32'h3, 32'h0, 1'b0, 3'b000, 3'b101, 7'h20, 5'd4, 1'b1);
        #1;
        check("basic.in_ready", 32'(in_ready), 32'd1);
        push_exp(32'h5, 32'h3, 32'h3);
        tick_pop("basic");

        // EX/MEM beats MEM/WB for the same register.
        set_instr(5'd7, 5'd7, 32'h111, 32'h222, 32'h0, 1'b0, 3'b001, 3'b000, 7'h00, 5'd8, 1'b1);
        set_fwd(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h5555);
        push_exp(32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000);
        tick_pop("fwd_exmem");

        // EX/MEM write disabled: MEM/WB supplies.
        set_instr(5'd7, 5'd7, 32'h111, 32'h222, 32'h0, 1'b0, 3'b010, 3'b001, 7'h01, 5'd9, 1'b0);
        set_fwd(1'b0, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h5555);
        push_exp(32'h5555, 32'h5555, 32'h5555);
        tick_pop("fwd_memwb");

        // x0 never forwarded.
        set_instr(5'd0, 5'd0, 32'h77, 32'h88, 32'h0, 1'b0, 3'b011, 3'b010, 7'h02, 5'd10, 1'b1);
        set_fwd(1'b1, 5'd0, 32'hDEAD0000, 1'b1, 5'd0, 32'hBEEF);
        push_exp(32'h77, 32'h88, 32'h88);
        tick_pop("fwd_x0");

        // Mixed: rs1 from MEM/WB, rs2 matches nothing.
        set_instr(5'd3, 5'd4, 32'h1, 32'h2, 32'h0, 1'b0, 3'b100, 3'b011, 7'h03, 5'd11, 1'b1);
        set_fwd(1'b1, 5'd9, 32'hDEAD0000, 1'b1, 5'd3, 32'hC0FFEE);
        push_exp(32'hC0FFEE, 32'h2, 32'h2);
        tick_pop("fwd_mixed");

        // Immediate select; store_data still carries forwarded rs2.
        set_instr(5'd1, 5'd9, 32'h42, 32'h99, 32'hFFFFFFFE, 1'b1, 3'b110, 3'b111, 7'h7F, 5'd31, 1'b1);
        set_fwd(1'b1, 5'd9, 32'h10, 1'b0, 5'd0, 32'h0);
        push_exp(32'h42, 32'hFFFFFFFE, 32'h10);
        tick_pop("imm");
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Backpressure: 3 stalled cycles, outputs must hold.
        out_ready = 1'b0;
        set_instr(5'd5, 5'd6, 32'h1234, 32'h5678, 32'h0, 1'b0, 3'b101, 3'b100, 7'h10, 5'd12, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.in_ready", 32'(in_ready), 32'd0);
            tick();
            check_out("stall.hold", cur, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 32'd1);
        push_exp(32'h1234, 32'h5678, 32'h5678);
        tick_pop("release_a");
        set_instr(5'd8, 5'd9, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 1'b0, 3'b111, 3'b110, 7'h40, 5'd13, 1'b1);
        push_exp(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A);
        tick_pop("release_b");

        // Drain: valid drops, reg_write clears, payload holds.
        in_valid = 1'b0;
        tick();
        cur.rw = 1'b0;
        check_out("drain", cur, 1'b0);

        // Flush while holding a live instruction and offering another.
        set_instr(5'd2, 5'd3, 32'h21, 32'h31, 32'h0, 1'b0, 3'b010, 3'b010, 7'h05, 5'd14, 1'b1);
        push_exp(32'h21, 32'h31, 32'h31);
        tick_pop("pre_flush");
        set_instr(5'd4, 5'd5, 32'hBAD0, 32'hBAD1, 32'h0, 1'b0, 3'b001, 3'b001, 7'h06, 5'd15, 1'b1);
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        check("flush.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.reg_write", 32'(reg_write), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush.dropped", 32'(out_valid), 32'd0);
        check("flush.op1_not_new", operand1, 32'h21);

        // Normal issue after flush.
        out_ready = 1'b1;
        set_instr(5'd6, 5'd0, 32'h600D, 32'h0, 32'h44, 1'b1, 3'b011, 3'b011, 7'h07, 5'd16, 1'b1);
        push_exp(32'h600D, 32'h44, 32'h0);
        tick_pop("post_flush");

        // Async reset between edges while stalled.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check_out("pre_areset.hold", cur, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("areset", zero_e, 1'b0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        set_instr(5'd1, 5'd2, 32'hF00D, 32'hCAFE, 32'h0, 1'b0, 3'b100, 3'b100, 7'h08, 5'd17, 1'b1);
        push_exp(32'hF00D, 32'hCAFE, 32'hCAFE);
        tick_pop("post_areset");
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
